// File: rtl/control_unit.sv
// control_unit: main instruction decoder for the KGP-RISC datapath.
// Maps the opcode and R-type function field to the full control word.
// The control word is registered, so it appears one clock after the fields
// are sampled. Any encoding that is not recognised decodes to an all-zero NOP.
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] instruction,
  input  logic [5:0] fn,
  output logic       ret,
  output logic       call,
  output logic [1:0] regdst,
  output logic [1:0] flag,
  output logic       branch,
  output logic       brnoeq,
  output logic       gotoreg,
  output logic       onlygoto,
  output logic       memtoreg,
  output logic       memread,
  output logic       memwrite,
  output logic [1:0] alusrc,
  output logic [2:0] aluctr,
  output logic       regwrite
);

  // Opcode encodings
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b000001;
  localparam logic [5:0] OP_SW    = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b000011;
  localparam logic [5:0] OP_COMPI = 6'b000100;
  localparam logic [5:0] OP_B     = 6'b100000;
  localparam logic [5:0] OP_BR    = 6'b100001;
  localparam logic [5:0] OP_BL    = 6'b100010;
  localparam logic [5:0] OP_RET   = 6'b100011;
  localparam logic [5:0] OP_BLTZ  = 6'b110000;
  localparam logic [5:0] OP_BZ    = 6'b110001;
  localparam logic [5:0] OP_BNZ   = 6'b110010;
  localparam logic [5:0] OP_BCY   = 6'b110011;
  localparam logic [5:0] OP_BNCY  = 6'b110100;

  // R-type function encodings
  localparam logic [5:0] FN_ADD   = 6'b000001;
  localparam logic [5:0] FN_COMP  = 6'b000010;
  localparam logic [5:0] FN_AND   = 6'b000011;
  localparam logic [5:0] FN_XOR   = 6'b000100;
  localparam logic [5:0] FN_SHLL  = 6'b000101;
  localparam logic [5:0] FN_SHRL  = 6'b000110;
  localparam logic [5:0] FN_SHLLV = 6'b000111;
  localparam logic [5:0] FN_SHRLV = 6'b001000;
  localparam logic [5:0] FN_SHRA  = 6'b001001;
  localparam logic [5:0] FN_SHRAV = 6'b001010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_COMP = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SHL  = 3'b100;
  localparam logic [2:0] ALU_SHRL = 3'b101;
  localparam logic [2:0] ALU_SHRA = 3'b110;

  // ALU operand-B sources
  localparam logic [1:0] SRC_RT    = 2'b00;
  localparam logic [1:0] SRC_IMM   = 2'b01;
  localparam logic [1:0] SRC_SHAMT = 2'b10;

  // Write-register selects
  localparam logic [1:0] DST_RS   = 2'b00;
  localparam logic [1:0] DST_RT   = 2'b01;
  localparam logic [1:0] DST_LINK = 2'b10;

  // Flag field: branch condition selects, or flag-update masks otherwise
  localparam logic [1:0] CND_ZERO  = 2'b00;
  localparam logic [1:0] CND_SIGN  = 2'b01;
  localparam logic [1:0] CND_CARRY = 2'b10;
  localparam logic [1:0] UPD_NONE  = 2'b00;
  localparam logic [1:0] UPD_ZS    = 2'b01;
  localparam logic [1:0] UPD_ALL   = 2'b11;

  // Next-state control word
  logic       ret_d;
  logic       call_d;
  logic [1:0] regdst_d;
  logic [1:0] flag_d;
  logic       branch_d;
  logic       brnoeq_d;
  logic       gotoreg_d;
  logic       onlygoto_d;
  logic       memtoreg_d;
  logic       memread_d;
  logic       memwrite_d;
  logic [1:0] alusrc_d;
  logic [2:0] aluctr_d;
  logic       regwrite_d;

  // Combinational decode of opcode/fn into the next control word (NOP by default)
  always_comb begin
    ret_d      = 1'b0;
    call_d     = 1'b0;
    regdst_d   = DST_RS;
    flag_d     = UPD_NONE;
    branch_d   = 1'b0;
    brnoeq_d   = 1'b0;
    gotoreg_d  = 1'b0;
    onlygoto_d = 1'b0;
    memtoreg_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    alusrc_d   = SRC_RT;
    aluctr_d   = ALU_ADD;
    regwrite_d = 1'b0;

    case (instruction)
      OP_RTYPE: begin
        // Every recognised fn writes rs; unknown fn stays a full NOP.
        case (fn)
          FN_ADD: begin
            regwrite_d = 1'b1;
            aluctr_d   = ALU_ADD;
            flag_d     = UPD_ALL;
          end
          FN_COMP: begin
            regwrite_d = 1'b1;
            aluctr_d   = ALU_COMP;
            flag_d     = UPD_ZS;
          end
          FN_AND: begin
            regwrite_d = 1'b1;
            aluctr_d   = ALU_AND;
            flag_d     = UPD_ZS;
          end
          FN_XOR: begin
            regwrite_d = 1'b1;
            aluctr_d   = ALU_XOR;
            flag_d     = UPD_ZS;
          end
          FN_SHLL: begin
            regwrite_d = 1'b1;
            aluctr_d   = ALU_SHL;
            alusrc_d   = SRC_SHAMT;
            flag_d     = UPD_ZS;
          end
          FN_SHRL: begin
            regwrite_d = 1'b1;
            aluctr_d   = ALU_SHRL;
            alusrc_d   = SRC_SHAMT;
            flag_d     = UPD_ZS;
          end
          FN_SHLLV: begin
            regwrite_d = 1'b1;
            aluctr_d   = ALU_SHL;
            flag_d     = UPD_ZS;
          end
          FN_SHRLV: begin
            regwrite_d = 1'b1;
            aluctr_d   = ALU_SHRL;
            flag_d     = UPD_ZS;
          end
          FN_SHRA: begin
            regwrite_d = 1'b1;
            aluctr_d   = ALU_SHRA;
            alusrc_d   = SRC_SHAMT;
            flag_d     = UPD_ZS;
          end
          FN_SHRAV: begin
            regwrite_d = 1'b1;
            aluctr_d   = ALU_SHRA;
            flag_d     = UPD_ZS;
          end
          default: begin
            regwrite_d = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        memread_d  = 1'b1;
        memtoreg_d = 1'b1;
        regwrite_d = 1'b1;
        regdst_d   = DST_RT;
        alusrc_d   = SRC_IMM;
        aluctr_d   = ALU_ADD;
      end
      OP_SW: begin
        memwrite_d = 1'b1;
        alusrc_d   = SRC_IMM;
        aluctr_d   = ALU_ADD;
      end
      OP_ADDI: begin
        regwrite_d = 1'b1;
        regdst_d   = DST_RS;
        alusrc_d   = SRC_IMM;
        aluctr_d   = ALU_ADD;
        flag_d     = UPD_ALL;
      end
      OP_COMPI: begin
        regwrite_d = 1'b1;
        regdst_d   = DST_RS;
        alusrc_d   = SRC_IMM;
        aluctr_d   = ALU_COMP;
        flag_d     = UPD_ZS;
      end
      OP_B: begin
        onlygoto_d = 1'b1;
      end
      OP_BR: begin
        gotoreg_d = 1'b1;
      end
      OP_BL: begin
        // Link writes PC+4 into $31 while jumping PC-relative.
        call_d     = 1'b1;
        onlygoto_d = 1'b1;
        regwrite_d = 1'b1;
        regdst_d   = DST_LINK;
      end
      OP_RET: begin
        ret_d = 1'b1;
      end
      OP_BLTZ: begin
        branch_d = 1'b1;
        flag_d   = CND_SIGN;
      end
      OP_BZ: begin
        branch_d = 1'b1;
        flag_d   = CND_ZERO;
      end
      OP_BNZ: begin
        branch_d = 1'b1;
        brnoeq_d = 1'b1;
        flag_d   = CND_ZERO;
      end
      OP_BCY: begin
        branch_d = 1'b1;
        flag_d   = CND_CARRY;
      end
      OP_BNCY: begin
        branch_d = 1'b1;
        brnoeq_d = 1'b1;
        flag_d   = CND_CARRY;
      end
      default: begin
        // Unknown opcodes (and X/Z fields) fall through to the NOP word.
        regwrite_d = 1'b0;
      end
    endcase
  end

  // Output register: reset forces NOP, otherwise capture the decoded word
  always_ff @(posedge clk) begin
    if (reset) begin
      ret      <= 1'b0;
      call     <= 1'b0;
      regdst   <= 2'b00;
      flag     <= 2'b00;
      branch   <= 1'b0;
      brnoeq   <= 1'b0;
      gotoreg  <= 1'b0;
      onlygoto <= 1'b0;
      memtoreg <= 1'b0;
      memread  <= 1'b0;
      memwrite <= 1'b0;
      alusrc   <= 2'b00;
      aluctr   <= 3'b000;
      regwrite <= 1'b0;
    end else begin
      ret      <= ret_d;
      call     <= call_d;
      regdst   <= regdst_d;
      flag     <= flag_d;
      branch   <= branch_d;
      brnoeq   <= brnoeq_d;
      gotoreg  <= gotoreg_d;
      onlygoto <= onlygoto_d;
      memtoreg <= memtoreg_d;
      memread  <= memread_d;
      memwrite <= memwrite_d;
      alusrc   <= alusrc_d;
      aluctr   <= aluctr_d;
      regwrite <= regwrite_d;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed, self-checking bench for control_unit.
// Each step drives instruction/fn (and reset), waits one rising edge, then
// compares the registered control word against a hand-written expectation.
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] instruction;
  logic [5:0] fn;
  logic       ret;
  logic       call;
  logic [1:0] regdst;
  logic [1:0] flag;
  logic       branch;
  logic       brnoeq;
  logic       gotoreg;
  logic       onlygoto;
  logic       memtoreg;
  logic       memread;
  logic       memwrite;
  logic [1:0] alusrc;
  logic [2:0] aluctr;
  logic       regwrite;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .fn          (fn),
    .ret         (ret),
    .call        (call),
    .regdst      (regdst),
    .flag        (flag),
    .branch      (branch),
    .brnoeq      (brnoeq),
    .gotoreg     (gotoreg),
    .onlygoto    (onlygoto),
    .memtoreg    (memtoreg),
    .memread     (memread),
    .memwrite    (memwrite),
    .alusrc      (alusrc),
    .aluctr      (aluctr),
    .regwrite    (regwrite)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed word, field order:
  // ret call regdst[1:0] flag[1:0] branch brnoeq gotoreg onlygoto
  // memtoreg memread memwrite alusrc[1:0] aluctr[2:0] regwrite
  logic [18:0] obs;
  assign obs = {ret, call, regdst, flag, branch, brnoeq, gotoreg, onlygoto,
                memtoreg, memread, memwrite, alusrc, aluctr, regwrite};

  function automatic logic [18:0] cw(
    input logic       r_ret, input logic r_call, input logic [1:0] r_regdst,
    input logic [1:0] r_flag, input logic r_branch, input logic r_brnoeq,
    input logic       r_gotoreg, input logic r_onlygoto, input logic r_memtoreg,
    input logic       r_memread, input logic r_memwrite, input logic [1:0] r_alusrc,
    input logic [2:0] r_aluctr, input logic r_regwrite);
    return {r_ret, r_call, r_regdst, r_flag, r_branch, r_brnoeq, r_gotoreg,
            r_onlygoto, r_memtoreg, r_memread, r_memwrite, r_alusrc, r_aluctr,
            r_regwrite};
  endfunction

  // Drive one set of inputs, clock once, check the registered word.
  task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] f,
                      input logic [18:0] exp, input string tag);
    reset       = rst;
    instruction = op;
    fn          = f;
    @(posedge clk);
    #1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Extra single-field checks used for the test-plan spot checks
  task automatic check_bit(input logic o, input logic e, input string tag);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, o, e);
    end
  endtask

  logic [18:0] NOP, LW, SW, ADDI, COMPI, B, BR, BL, RET, BLTZ, BZ, BNZ, BCY, BNCY;
  logic [18:0] ADD, COMP, AND_, XOR_, SHLL, SHRL, SHLLV, SHRLV, SHRA, SHRAV;

  initial begin
    //             ret  call dst    flag   br   bne  greg goto m2r  mrd  mwr  src    alu     rw
    NOP   = 19'b0;
    ADD   = cw(1'b0,1'b0,2'b00,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b1);
    COMP  = cw(1'b0,1'b0,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001,1'b1);
    AND_  = cw(1'b0,1'b0,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b010,1'b1);
    XOR_  = cw(1'b0,1'b0,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b011,1'b1);
    SHLL  = cw(1'b0,1'b0,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,3'b100,1'b1);
    SHRL  = cw(1'b0,1'b0,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,3'b101,1'b1);
    SHLLV = cw(1'b0,1'b0,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b100,1'b1);
    SHRLV = cw(1'b0,1'b0,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b101,1'b1);
    SHRA  = cw(1'b0,1'b0,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,3'b110,1'b1);
    SHRAV = cw(1'b0,1'b0,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b110,1'b1);
    LW    = cw(1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b01,3'b000,1'b1);
    SW    = cw(1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,3'b000,1'b0);
    ADDI  = cw(1'b0,1'b0,2'b00,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,1'b1);
    COMPI = cw(1'b0,1'b0,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b001,1'b1);
    B     = cw(1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0);
    BR    = cw(1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0);
    BL    = cw(1'b0,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,1'b1);
    RET   = cw(1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0);
    BLTZ  = cw(1'b0,1'b0,2'b00,2'b01,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0);
    BZ    = cw(1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0);
    BNZ   = cw(1'b0,1'b0,2'b00,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0);
    BCY   = cw(1'b0,1'b0,2'b00,2'b10,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0);
    BNCY  = cw(1'b0,1'b0,2'b00,2'b10,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,1'b0);

    reset       = 1'b1;
    instruction = 6'b000001;
    fn          = 6'b000000;

    // Reset held two cycles with lw on the inputs
    step(1'b1, 6'b000001, 6'b000000, NOP, "reset_c1");
    step(1'b1, 6'b000001, 6'b000000, NOP, "reset_c2");
    // Release: lw word appears after the first edge with reset low
    step(1'b0, 6'b000001, 6'b000000, LW, "lw_after_reset");
    check_bit(memread,  1'b1, "lw_memread");
    check_bit(memtoreg, 1'b1, "lw_memtoreg");

    // R-type spot checks
    step(1'b0, 6'b000000, 6'b000001, ADD, "rtype_add");
    check_bit(flag == 2'b11, 1'b1, "add_flag11");
    step(1'b0, 6'b000000, 6'b000100, XOR_, "rtype_xor");

    // Memory
    step(1'b0, 6'b000001, 6'b000000, LW, "mem_lw");
    step(1'b0, 6'b000010, 6'b000000, SW, "mem_sw");
    check_bit(regwrite, 1'b0, "sw_regwrite");
    check_bit(memread,  1'b0, "sw_memread");

    // Branches
    step(1'b0, 6'b110001, 6'b000000, BZ,   "br_bz");
    step(1'b0, 6'b110010, 6'b000000, BNZ,  "br_bnz");
    step(1'b0, 6'b110100, 6'b000000, BNCY, "br_bncy");
    step(1'b0, 6'b100010, 6'b000000, BL,   "br_bl");
    check_bit(call, 1'b1, "bl_call");

    // Illegal encodings decode to NOP
    step(1'b0, 6'b111111, 6'b000000, NOP, "illegal_op");
    step(1'b0, 6'b000000, 6'b111111, NOP, "illegal_fn");
    step(1'b0, 6'b000000, 6'b000000, NOP, "illegal_fn0");
    step(1'b0, 6'b000101, 6'b000001, NOP, "illegal_op5");

    // fn must be ignored for non-zero opcodes
    step(1'b0, 6'b000011, 6'b111111, ADDI, "addi_fn_ignored");
    step(1'b0, 6'b110011, 6'b000001, BCY,  "bcy_fn_ignored");

    // Back-to-back sweep across every legal encoding
    step(1'b0, 6'b000000, 6'b000001, ADD,   "sw_add");
    step(1'b0, 6'b000000, 6'b000010, COMP,  "sw_comp");
    step(1'b0, 6'b000000, 6'b000011, AND_,  "sw_and");
    step(1'b0, 6'b000000, 6'b000100, XOR_,  "sw_xor");
    step(1'b0, 6'b000000, 6'b000101, SHLL,  "sw_shll");
    step(1'b0, 6'b000000, 6'b000110, SHRL,  "sw_shrl");
    step(1'b0, 6'b000000, 6'b000111, SHLLV, "sw_shllv");
    step(1'b0, 6'b000000, 6'b001000, SHRLV, "sw_shrlv");
    step(1'b0, 6'b000000, 6'b001001, SHRA,  "sw_shra");
    step(1'b0, 6'b000000, 6'b001010, SHRAV, "sw_shrav");
    step(1'b0, 6'b000001, 6'b000000, LW,    "sw_lw");
    step(1'b0, 6'b000010, 6'b000000, SW,    "sw_sw");
    step(1'b0, 6'b000011, 6'b000000, ADDI,  "sw_addi");
    step(1'b0, 6'b000100, 6'b000000, COMPI, "sw_compi");
    step(1'b0, 6'b100000, 6'b000000, B,     "sw_b");
    step(1'b0, 6'b100001, 6'b000000, BR,    "sw_br");
    step(1'b0, 6'b100010, 6'b000000, BL,    "sw_bl");
    step(1'b0, 6'b100011, 6'b000000, RET,   "sw_ret");
    step(1'b0, 6'b110000, 6'b000000, BLTZ,  "sw_bltz");
    step(1'b0, 6'b110001, 6'b000000, BZ,    "sw_bz");
    step(1'b0, 6'b110010, 6'b000000, BNZ,   "sw_bnz");
    step(1'b0, 6'b110011, 6'b000000, BCY,   "sw_bcy");
    step(1'b0, 6'b110100, 6'b000000, BNCY,  "sw_bncy");

    // Mid-stream reset wins over a legal instruction, then decode resumes
    step(1'b1, 6'b000011, 6'b000000, NOP,  "midreset");
    step(1'b0, 6'b100011, 6'b000000, RET,  "after_midreset");
    step(1'b0, 6'b000000, 6'b001001, SHRA, "after_midreset2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
